lcd_row_formatter: RTL and testbench

//  Upstream feeder for the 16x2 character-LCD driver: converts two unsigned

---
 rtl/lcd_row_formatter_pkg.sv | 40 ++++
 rtl/lcd_row_formatter_if.sv | 24 ++
 rtl/lcd_row_formatter_bin2bcd_seq.sv | 60 ++++++
 rtl/lcd_row_formatter.sv | 108 ++++++++++
 tb/tb_lcd_row_formatter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/lcd_row_formatter_pkg.sv
// Shared constants, FSM state type and the BCD-to-ASCII field helper for
// lcd_row_formatter.
package lcd_row_formatter_pkg;

  localparam logic [7:0]   ASCII_SPACE = 8'h20;
  localparam logic [7:0]   ASCII_ZERO  = 8'h30;
  localparam int unsigned  FIELD_CHARS = 10;
  localparam int unsigned  BCD_DIGITS  = 10;
  localparam int unsigned  BCD_BITS    = 4 * BCD_DIGITS;
  localparam int unsigned  ROW_BITS    = 128;
  localparam logic [127:0] ROW_BLANK   = {16{ASCII_SPACE}};

  typedef enum logic [1:0] {
    StIdle,
    StConv0,
    StConv1,
    StCommit
  } state_e;

  // Right-justified decimal field; zeros above the most significant nonzero
  // digit become spaces, but the units digit is always printed.
  function automatic logic [8*FIELD_CHARS-1:0] bcd_to_field(input logic [BCD_BITS-1:0] bcd);
    logic [8*FIELD_CHARS-1:0] field;
    logic                     lead;
    logic [3:0]               d;
    field = '0;
    lead  = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (lead && (d == 4'd0) && (i != 0)) begin
        field[8*i +: 8] = ASCII_SPACE;
      end else begin
        lead            = 1'b0;
        field[8*i +: 8] = ASCII_ZERO + {4'd0, d};
      end
    end
    return field;
  endfunction

endpackage

// File: rtl/lcd_row_formatter_if.sv
// Value-in / row-out bundle of lcd_row_formatter.
//   master: upstream side, drives val_valid/val0/val1, observes ready and rows
//   slave : the formatter itself
interface lcd_row_formatter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             val_valid;
  logic             val_ready;
  logic [WIDTH-1:0] val0;
  logic [WIDTH-1:0] val1;
  logic [127:0]     row0;
  logic [127:0]     row1;
  logic             rows_updated;

  modport master (
    output val_valid, val0, val1,
    input  val_ready, row0, row1, rows_updated
  );

  modport slave (
    input  val_valid, val0, val1,
    output val_ready, row0, row1, rows_updated
  );
endinterface

// File: rtl/lcd_row_formatter_bin2bcd_seq.sv
// Sequential double-dabble converter, one add-3/shift step per cycle.
//   clk, reset_n : clock, synchronous active-low reset
//   load, value  : start a conversion of value (restarts any conversion)
//   done         : high in the cycle whose edge performs the last step
//   bcd          : 10-digit BCD after the step taken on the next edge; valid
//                  as the final result while done is high
module lcd_row_formatter_bin2bcd_seq
  import lcd_row_formatter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [WIDTH-1:0]    value,
  output logic                done,
  output logic [BCD_BITS-1:0] bcd
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]          bin_q;
  logic [BCD_BITS-1:0]       bcd_q;
  logic [BCD_BITS-1:0]       adj;
  logic [CntW-1:0]           cnt_q;
  logic                      busy_q;
  logic [BCD_BITS+WIDTH-1:0] shifted;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
  end

  // Exposing the post-step value lets the caller capture on the WIDTH-th edge.
  assign bcd  = shifted[BCD_BITS+WIDTH-1 -: BCD_BITS];
  assign done = busy_q && (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      bin_q  <= value;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= shifted[WIDTH-1:0];
      bcd_q <= bcd;
      if (done) busy_q <= 1'b0;
      else      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_row_formatter.sv
// Converts two unsigned values to right-justified decimal ASCII and commits
// both 16-character LCD rows together on a single edge.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : slave side of lcd_row_formatter_if (val_valid/val_ready
//                  handshake, val0/val1 in, row0/row1 and rows_updated out)
// Byte [127:120] of each row is the leftmost character.
module lcd_row_formatter
  import lcd_row_formatter_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter logic [47:0] LABEL0 = "VAL0: ",
  parameter logic [47:0] LABEL1 = "VAL1: "
) (
  input logic                clk,
  input logic                reset_n,
  lcd_row_formatter_if.slave bus
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    val1_q;
  logic [BCD_BITS-1:0] digits0_q, digits1_q;
  logic [127:0]        row0_q, row1_q;
  logic                rows_updated_q;

  logic                conv_load;
  logic [WIDTH-1:0]    conv_value;
  logic                conv_done;
  logic [BCD_BITS-1:0] conv_bcd;
  logic                accept, cap0, cap1, commit;

  // One converter, time-shared: val0 first, then the latched val1.
  lcd_row_formatter_bin2bcd_seq #(
    .WIDTH (WIDTH)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (conv_load),
    .value   (conv_value),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    conv_load  = 1'b0;
    conv_value = bus.val0;
    accept     = 1'b0;
    cap0       = 1'b0;
    cap1       = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.val_valid) begin
          accept    = 1'b1;
          conv_load = 1'b1;
          state_d   = StConv0;
        end
      end
      StConv0: begin
        conv_value = val1_q;
        if (conv_done) begin
          cap0      = 1'b1;
          conv_load = 1'b1;
          state_d   = StConv1;
        end
      end
      StConv1: begin
        if (conv_done) begin
          cap1    = 1'b1;
          state_d = StCommit;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      val1_q         <= '0;
      digits0_q      <= '0;
      digits1_q      <= '0;
      row0_q         <= ROW_BLANK;
      row1_q         <= ROW_BLANK;
      rows_updated_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rows_updated_q <= commit;
      if (accept) val1_q    <= bus.val1;
      if (cap0)   digits0_q <= conv_bcd;
      if (cap1)   digits1_q <= conv_bcd;
      if (commit) begin
        row0_q <= {LABEL0, bcd_to_field(digits0_q)};
        row1_q <= {LABEL1, bcd_to_field(digits1_q)};
      end
    end
  end

  assign bus.val_ready    = (state_q == StIdle);
  assign bus.row0         = row0_q;
  assign bus.row1         = row1_q;
  assign bus.rows_updated = rows_updated_q;

endmodule

// File: tb/tb_lcd_row_formatter.sv
// Directed bench for lcd_row_formatter: WIDTH=16 and WIDTH=32 instances.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lcd_row_formatter;

  localparam logic [7:0]   SP    = 8'h20;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   pulses;

  lcd_row_formatter_if #(.WIDTH(16)) bus16 ();
  lcd_row_formatter_if #(.WIDTH(32)) bus32 ();

  lcd_row_formatter #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus16)
  );

  lcd_row_formatter #(.WIDTH(32)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h (\"%s\") expected %h (\"%s\")", tag, obs, obs, exp, exp);
    end
  endtask

  // Full WIDTH=16 transaction; inputs are scrambled after the accept edge.
  task automatic run16(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                       input logic [127:0] e0, input logic [127:0] e1);
    @(negedge clk);
    bus16.val_valid = 1'b1;
    bus16.val0      = v0;
    bus16.val1      = v1;
    @(negedge clk);                      // after accept edge E0
    bus16.val_valid = 1'b0;
    bus16.val0      = ~v0;
    bus16.val1      = ~v1;
    chk({tag, "_busy"}, {127'd0, bus16.val_ready}, 128'd0);
    repeat (32) @(negedge clk);          // after E32
    chk({tag, "_nopulse"}, {127'd0, bus16.rows_updated}, 128'd0);
    @(negedge clk);                      // after E33
    chk({tag, "_pulse"}, {127'd0, bus16.rows_updated}, 128'd1);
    chk({tag, "_ready"}, {127'd0, bus16.val_ready}, 128'd1);
    chk({tag, "_row0"}, bus16.row0, e0);
    chk({tag, "_row1"}, bus16.row1, e1);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {127'd0, bus16.rows_updated}, 128'd0);
    chk({tag, "_row0_hold"}, bus16.row0, e0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset_n         = 1'b0;
    bus16.val_valid = 1'b0;
    bus16.val0      = '0;
    bus16.val1      = '0;
    bus32.val_valid = 1'b0;
    bus32.val0      = '0;
    bus32.val1      = '0;

    // 1. reset state
    repeat (3) @(negedge clk);
    chk("rst_row0", bus16.row0, BLANK);
    chk("rst_row1", bus16.row1, BLANK);
    chk("rst_ready", {127'd0, bus16.val_ready}, 128'd1);
    chk("rst_upd", {127'd0, bus16.rows_updated}, 128'd0);
    chk("rst32_row0", bus32.row0, BLANK);
    reset_n = 1'b1;

    // 2. zero and full-scale
    run16("t2", 16'd0, 16'd65535, {"VAL0: ", {9{SP}}, "0"}, {"VAL1: ", {5{SP}}, "65535"});

    // 3. interior zeros kept
    run16("t3", 16'd1234, 16'd100, {"VAL0: ", {6{SP}}, "1234"}, {"VAL1: ", {7{SP}}, "100"});

    // 4. valid held high, values change every cycle; accepts at E0 and E34
    pulses = 0;
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk);
      if (bus16.rows_updated === 1'b1) pulses++;
      if (k == 34) begin
        chk("t4_row0_a", bus16.row0, {"VAL0: ", {6{SP}}, "1000"});
        chk("t4_row1_a", bus16.row1, {"VAL1: ", {6{SP}}, "2000"});
        chk("t4_ready_a", {127'd0, bus16.val_ready}, 128'd1);
      end
      if (k == 35) chk("t4_busy_b", {127'd0, bus16.val_ready}, 128'd0);
      if (k == 68) begin
        chk("t4_row0_b", bus16.row0, {"VAL0: ", {6{SP}}, "1034"});
        chk("t4_row1_b", bus16.row1, {"VAL1: ", {6{SP}}, "2034"});
      end
      bus16.val_valid = 1'b1;
      bus16.val0      = 16'(1000 + k);
      bus16.val1      = 16'(2000 + k);
    end
    bus16.val_valid = 1'b0;
    chk("t4_pulses", 128'(pulses), 128'd2);
    repeat (40) @(negedge clk);          // let the E68 transaction drain

    // 5. reset during CONV1
    @(negedge clk);
    bus16.val_valid = 1'b1;
    bus16.val0      = 16'd7;
    bus16.val1      = 16'd8;
    @(negedge clk);                      // after E0
    bus16.val_valid = 1'b0;
    repeat (20) @(negedge clk);          // after E20: converting val1
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t5_row0", bus16.row0, BLANK);
    chk("t5_row1", bus16.row1, BLANK);
    chk("t5_ready", {127'd0, bus16.val_ready}, 128'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus16.rows_updated === 1'b1) pulses++;
    end
    chk("t5_nopulse", 128'(pulses), 128'd0);
    chk("t5_row0_still", bus16.row0, BLANK);
    run16("t5b", 16'd42, 16'd7, {"VAL0: ", {8{SP}}, "42"}, {"VAL1: ", {9{SP}}, "7"});

    // 6. WIDTH=32: latency 65 edges
    @(negedge clk);
    bus32.val_valid = 1'b1;
    bus32.val0      = 32'hFFFF_FFFF;
    bus32.val1      = 32'd1;
    @(negedge clk);                      // after E0
    bus32.val_valid = 1'b0;
    bus32.val0      = '0;
    bus32.val1      = '0;
    repeat (64) @(negedge clk);          // after E64
    chk("t6_nopulse", {127'd0, bus32.rows_updated}, 128'd0);
    chk("t6_busy", {127'd0, bus32.val_ready}, 128'd0);
    @(negedge clk);                      // after E65
    chk("t6_pulse", {127'd0, bus32.rows_updated}, 128'd1);
    chk("t6_row0", bus32.row0, {"VAL0: ", "4294967295"});
    chk("t6_row1", bus32.row1, {"VAL1: ", {9{SP}}, "1"});
    chk("t6_dut16_row0", bus16.row0, {"VAL0: ", {8{SP}}, "42"});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
